// File: rtl/rvc_asap_5pl_fetch.sv
// Instruction-fetch initiator for the 5-stage core.
// Drives a synchronous-read I_MEM that has one cycle of read latency.
// Each returned word is paired with its PC and presented to decode as a
// valid/ready stream. A 2-entry buffer catches words already in flight
// when decode stalls. Redirects flush everything and restart fetch.
module rvc_asap_5pl_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_q,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  logic [31:0] pc_q;
  logic        infl_v;
  logic [31:0] infl_pc;
  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_inst [2];
  logic        rd;
  logic        wr;
  logic [1:0]  count;

  logic        head_v;
  logic [31:0] head_pc;
  logic [31:0] head_inst;
  logic        pop;
  logic        buf_pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;
  logic [31:0] target;
  logic        unused_low_bits;

  assign target          = {redirect_pc[31:2], 2'b00};
  assign unused_low_bits = ^redirect_pc[1:0];
  assign imem_address    = pc_q;

  // Select the head word (buffer first, else the in-flight bypass) and derive handshake/issue controls
  always_comb begin
    head_v    = 1'b0;
    head_pc   = 32'h0000_0000;
    head_inst = 32'h0000_0000;
    if (count != 2'd0) begin
      head_v    = 1'b1;
      head_pc   = fifo_pc[rd];
      head_inst = fifo_inst[rd];
    end else if (infl_v) begin
      head_v    = 1'b1;
      head_pc   = infl_pc;
      head_inst = imem_q;
    end else begin
      head_v    = 1'b0;
      head_pc   = 32'h0000_0000;
      head_inst = 32'h0000_0000;
    end

    inst_valid = head_v & ~redirect_valid;
    if (inst_valid) begin
      inst    = head_inst;
      inst_pc = head_pc;
    end else begin
      inst    = 32'h0000_0000;
      inst_pc = 32'h0000_0000;
    end

    pop     = inst_valid & ready;
    // The in-flight word is the popped head only when the buffer is empty.
    buf_pop = pop & (count != 2'd0);
    push    = infl_v & ~(pop & (count == 2'd0));

    occupancy = {1'b0, count} + {2'b00, infl_v} - {2'b00, pop};
    issue     = ~redirect_valid & (occupancy < 3'd2);
  end

  // Control state: PC, in-flight tracking, buffer pointers and count
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      infl_v  <= 1'b0;
      infl_pc <= 32'h0000_0000;
      rd      <= 1'b0;
      wr      <= 1'b0;
      count   <= 2'd0;
    end else if (redirect_valid) begin
      pc_q    <= target;
      infl_v  <= 1'b0;
      infl_pc <= infl_pc;
      rd      <= 1'b0;
      wr      <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push) begin
        wr <= ~wr;
      end else begin
        wr <= wr;
      end
      if (buf_pop) begin
        rd <= ~rd;
      end else begin
        rd <= rd;
      end
      count <= count + {1'b0, push} - {1'b0, buf_pop};
      if (issue) begin
        infl_v  <= 1'b1;
        infl_pc <= pc_q;
        pc_q    <= pc_q + 32'd4;
      end else begin
        infl_v  <= 1'b0;
        infl_pc <= infl_pc;
        pc_q    <= pc_q;
      end
    end
  end

  // Buffer storage; contents need no reset because count gates every read
  always_ff @(posedge clock) begin
    if (rst_n && !redirect_valid && push) begin
      fifo_pc[wr]   <= infl_pc;
      fifo_inst[wr] <= imem_q;
    end
  end

endmodule

// File: tb/tb_rvc_asap_5pl_fetch.sv
// Self-checking bench for rvc_asap_5pl_fetch: directed scenarios followed by
// randomized ready/redirect/reset traffic, compared cycle by cycle against a
// queue-based reference of the fetch stream.
module tb_rvc_asap_5pl_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock;
  logic        rst_n;
  logic        ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_address;
  logic [31:0] imem_q;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: PCs whose data is visible this cycle, oldest first
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  bit          m_init = 1'b0;

  rvc_asap_5pl_fetch #(.RESET_PC(RESET_PC)) dut (
    .clock          (clock),
    .rst_n          (rst_n),
    .ready          (ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_address   (imem_address),
    .imem_q         (imem_q),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    case (a)
      32'd0:   return 32'd11;
      32'd4:   return 32'd22;
      32'd8:   return 32'd33;
      32'd12:  return 32'd44;
      default: return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  // Synchronous-read instruction memory, one cycle of latency
  always @(posedge clock) imem_q <= memfn(imem_address);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the reference
  task automatic run_cycle(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    bit ev;
    bit pop;
    int occ;
    rst_n = r; ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    @(negedge clock);
    if (m_init) begin
      ev = (m_q.size() > 0) && !rv;
      check_eq("imem_address", imem_address, m_pc);
      check_eq("inst_valid", {31'd0, inst_valid}, {31'd0, ev});
      check_eq("inst", inst, ev ? memfn(m_q[0]) : 32'd0);
      check_eq("inst_pc", inst_pc, ev ? m_q[0] : 32'd0);
      check_eq("push_at_full", {31'd0, (dut.push && dut.count == 2'd2)}, 32'd0);
    end else begin
      ev = 1'b0;
    end
    pop = ev && rdy;
    if (!r) begin
      m_q.delete();
      m_pc   = RESET_PC;
      m_init = 1'b1;
    end else if (m_init) begin
      if (rv) begin
        m_q.delete();
        m_pc = {rpc[31:2], 2'b00};
      end else begin
        occ = m_q.size() - (pop ? 1 : 0);
        if (pop) void'(m_q.pop_front());
        if (occ < 2) begin
          m_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run_n(input int n, input logic rdy);
    for (int i = 0; i < n; i++) run_cycle(1'b1, rdy, 1'b0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    // Reset, then stream with ready=1
    run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
    run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
    run_n(2, 1'b1);           // cycle 0 (issue), cycle 1 presents pc 0
    // Stall 5 cycles while pc 4 is presented, then release
    run_n(5, 1'b0);
    run_n(6, 1'b1);
    // Redirect to 0x103 with a full buffer, ready high
    run_n(3, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    run_n(4, 1'b1);
    // Same redirect with ready low in the same cycle
    run_n(3, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    run_n(4, 1'b1);
    // Wrap-around of the fetch address
    run_cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    run_n(6, 1'b1);
    // Mid-operation reset while full and redirecting
    run_n(3, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    run_n(4, 1'b1);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic rdy;
      logic rv;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 99) != 0);
      rdy = ($urandom_range(0, 99) < 65);
      rv  = ($urandom_range(0, 99) < 6);
      rpc = $urandom();
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'h0000_000F);
      run_cycle(r, rdy, rv, rpc);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
